k6502_alu_seq: RTL and testbench

Parametrised, handshaked successor to the k6502 single-cycle ALU. It adds a full 6502 operation set (logic, shifts and rotates, compare, BIT) and a sequential nibble-serial BCD adder/subtractor for decimal mode. Results, flags and a flag-write mask are registered. It sits between the instruction sequencer (which issues `start`/`op`) and the register file/status register (which consume `done`, `data_out`, `sr_out` and `sr_mask`).

---
 rtl/k6502_alu_seq_pkg.sv | 49 ++++
 rtl/k6502_alu_seq_bcd_nibble.sv | 28 ++
 rtl/k6502_alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_k6502_alu_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/k6502_alu_seq_pkg.sv
// Shared opcodes, status-register bit positions, flag-write masks and FSM encodings
// for the handshaked k6502 ALU.
package k6502_alu_seq_pkg;

  // Legacy encodings 0..4 are kept; the extended 6502 set follows.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_INC = 4'd1;
  localparam logic [3:0] OP_DEC = 4'd2;
  localparam logic [3:0] OP_TST = 4'd3;
  localparam logic [3:0] OP_BAD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_ORA = 4'd6;
  localparam logic [3:0] OP_EOR = 4'd7;
  localparam logic [3:0] OP_ASL = 4'd8;
  localparam logic [3:0] OP_LSR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
  localparam logic [3:0] OP_SUB = 4'd12;
  localparam logic [3:0] OP_CMP = 4'd13;
  localparam logic [3:0] OP_BIT = 4'd14;

  localparam int SR_C = 0;
  localparam int SR_Z = 1;
  localparam int SR_D = 3;
  localparam int SR_V = 6;
  localparam int SR_N = 7;

  localparam logic [7:0] MSK_NVZC = 8'hC3;
  localparam logic [7:0] MSK_NVZ  = 8'hC2;
  localparam logic [7:0] MSK_NZC  = 8'h83;
  localparam logic [7:0] MSK_NZ   = 8'h82;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DADJ = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic [7:0] sr_pack(input logic n, input logic v,
                                         input logic z, input logic c);
    logic [7:0] s;
    s       = '0;
    s[SR_N] = n;
    s[SR_V] = v;
    s[SR_Z] = z;
    s[SR_C] = c;
    return s;
  endfunction

endpackage

// File: rtl/k6502_alu_seq_bcd_nibble.sv
// One BCD digit of add/subtract. c_i/c_o are carry (add) or not-borrow (sub).
module bcd_nibble
  import k6502_alu_seq_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  input  logic       sub_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] raw;

  always_comb begin
    raw = '0;
    s_o = '0;
    c_o = 1'b0;
    if (sub_i) begin
      raw = {1'b0, a_i} + {1'b0, ~b_i} + {4'd0, c_i};
      c_o = raw[4];
      s_o = raw[4] ? raw[3:0] : raw[3:0] - 4'd6;
    end else begin
      raw = {1'b0, a_i} + {1'b0, b_i} + {4'd0, c_i};
      c_o = (raw > 5'd9);
      s_o = c_o ? 4'(raw + 5'd6) : raw[3:0];
    end
  end
endmodule

// File: rtl/k6502_alu_seq.sv
// Handshaked 6502 ALU: single-cycle binary ops, nibble-serial BCD add/sub,
// registered result/flags/mask with a one-cycle done pulse.
module k6502_alu_seq
  import k6502_alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_ARGS   = 8,
  parameter int DECIMAL_EN = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [3:0]                  op_i,
  input  logic [$clog2(NUM_ARGS)-1:0] arg_sel_i,
  input  logic [NUM_ARGS*WIDTH-1:0]   args_i,
  input  logic [WIDTH-1:0]            data_in_i,
  input  logic [7:0]                  sr_in_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [WIDTH-1:0]            data_out_o,
  output logic [7:0]                  sr_out_o,
  output logic [7:0]                  sr_mask_o,
  output logic [1:0]                  b_sr_o
);
  localparam int NW = (WIDTH / 4 > 1) ? $clog2(WIDTH / 4) : 1;
  localparam logic [NW-1:0] LAST = NW'(WIDTH / 4 - 1);

  logic [NUM_ARGS-1:0][WIDTH-1:0] args_arr;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, dres_q, data_out_q;
  logic [3:0]       op_q;
  logic             c_q, vin_q, dcar_q;
  logic [NW-1:0]    nib_q;
  logic [7:0]       sr_out_q, sr_mask_q;
  logic [1:0]       b_sr_q;

  logic             start_ok, dec_go, load_out;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res, nz, dec_res, res_d;
  logic             fn, fv, fz, fc;
  logic [7:0]       mask, sr_d, mask_d;
  logic [3:0]       a_nib, b_nib, nib_s;
  logic             nib_co;
  logic             unused_sr;

  assign args_arr  = args_i;
  assign busy_o    = (state_q == ST_EXEC) || (state_q == ST_DADJ);
  assign done_o    = (state_q == ST_DONE);
  assign start_ok  = start_i && !busy_o;
  assign dec_go    = (DECIMAL_EN != 0) && sr_in_i[SR_D] && (op_i == OP_ADD || op_i == OP_SUB);
  assign load_out  = (state_q == ST_EXEC) || (state_q == ST_DADJ && nib_q == LAST);
  assign unused_sr = ^{sr_in_i[7], sr_in_i[5:4], sr_in_i[2:1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = start_i ? (dec_go ? ST_DADJ : ST_EXEC) : ST_IDLE;
      ST_EXEC:          state_d = ST_DONE;
      ST_DADJ:          if (nib_q == LAST) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Binary datapath; V (and C/V for BAD) is also used by the decimal path.
  always_comb begin
    sum  = '0;
    res  = '0;
    nz   = '0;
    fc   = c_q;
    fv   = vin_q;
    mask = '0;
    case (op_q)
      OP_ADD, OP_BAD: begin
        sum  = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'((op_q == OP_BAD) ? 1'b1 : c_q);
        res  = sum[WIDTH-1:0];
        nz   = res;
        fc   = sum[WIDTH];
        fv   = (a_q[WIDTH-1] ^ res[WIDTH-1]) & (b_q[WIDTH-1] ^ res[WIDTH-1]);
        mask = (op_q == OP_BAD) ? 8'h00 : MSK_NVZC;
      end
      OP_SUB: begin
        sum  = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(c_q);
        res  = sum[WIDTH-1:0];
        nz   = res;
        fc   = sum[WIDTH];
        fv   = (a_q[WIDTH-1] ^ res[WIDTH-1]) & (~b_q[WIDTH-1] ^ res[WIDTH-1]);
        mask = MSK_NVZC;
      end
      OP_AND: begin res = a_q & b_q; nz = res; mask = MSK_NZ; end
      OP_ORA: begin res = a_q | b_q; nz = res; mask = MSK_NZ; end
      OP_EOR: begin res = a_q ^ b_q; nz = res; mask = MSK_NZ; end
      OP_ASL: begin res = {a_q[WIDTH-2:0], 1'b0}; nz = res; fc = a_q[WIDTH-1]; mask = MSK_NZC; end
      OP_LSR: begin res = {1'b0, a_q[WIDTH-1:1]}; nz = res; fc = a_q[0];       mask = MSK_NZC; end
      OP_ROL: begin res = {a_q[WIDTH-2:0], c_q};  nz = res; fc = a_q[WIDTH-1]; mask = MSK_NZC; end
      OP_ROR: begin res = {c_q, a_q[WIDTH-1:1]};  nz = res; fc = a_q[0];       mask = MSK_NZC; end
      OP_INC: begin res = a_q + WIDTH'(1); nz = res; mask = MSK_NZ; end
      OP_DEC: begin res = a_q - WIDTH'(1); nz = res; mask = MSK_NZ; end
      OP_CMP: begin
        sum  = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        res  = a_q;
        nz   = sum[WIDTH-1:0];
        fc   = sum[WIDTH];
        mask = MSK_NZC;
      end
      OP_BIT: begin res = a_q; nz = a_q & b_q; fv = b_q[WIDTH-2]; mask = MSK_NVZ; end
      OP_TST: begin res = b_q; nz = b_q; mask = MSK_NZ; end
      default: ;
    endcase
    fn = (op_q == OP_BIT) ? b_q[WIDTH-1] : nz[WIDTH-1];
    fz = ~|nz;
  end

  // Operand digits are picked by the nibble counter; result digits shift in from the top.
  assign a_nib   = 4'(a_q >> {nib_q, 2'b00});
  assign b_nib   = 4'(b_q >> {nib_q, 2'b00});
  assign dec_res = {nib_s, dres_q[WIDTH-1:4]};

  if (DECIMAL_EN != 0) begin : g_bcd
    bcd_nibble u_bcd (
      .a_i  (a_nib),
      .b_i  (b_nib),
      .c_i  (dcar_q),
      .sub_i(op_q == OP_SUB),
      .s_o  (nib_s),
      .c_o  (nib_co)
    );
  end else begin : g_nobcd
    logic unused_nib;
    assign unused_nib = ^{a_nib, b_nib, dcar_q};
    assign nib_s      = '0;
    assign nib_co     = 1'b0;
  end

  always_comb begin
    if (state_q == ST_DADJ) begin
      res_d  = dec_res;
      sr_d   = sr_pack(dec_res[WIDTH-1], fv, ~|dec_res, nib_co);
      mask_d = MSK_NVZC;
    end else begin
      res_d  = res;
      sr_d   = sr_pack(fn, fv, fz, fc);
      mask_d = mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      c_q        <= 1'b0;
      vin_q      <= 1'b0;
      nib_q      <= '0;
      dres_q     <= '0;
      dcar_q     <= 1'b0;
      data_out_q <= '0;
      sr_out_q   <= '0;
      sr_mask_q  <= '0;
      b_sr_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        a_q    <= args_arr[arg_sel_i];
        b_q    <= data_in_i;
        op_q   <= op_i;
        c_q    <= sr_in_i[SR_C];
        vin_q  <= sr_in_i[SR_V];
        nib_q  <= '0;
        dres_q <= '0;
        dcar_q <= sr_in_i[SR_C];
      end else if (state_q == ST_DADJ) begin
        nib_q  <= nib_q + 1'b1;
        dres_q <= dec_res;
        dcar_q <= nib_co;
      end
      if (load_out) begin
        data_out_q <= res_d;
        sr_out_q   <= sr_d;
        sr_mask_q  <= mask_d;
        if (op_q == OP_BAD) b_sr_q <= {fv, fc};
      end
    end
  end

  assign data_out_o = data_out_q;
  assign sr_out_o   = sr_out_q;
  assign sr_mask_o  = sr_mask_q;
  assign b_sr_o     = b_sr_q;
endmodule

// File: tb/tb_k6502_alu_seq.sv
// Directed bench: hand-computed vectors for binary, decimal, handshake and reset behaviour.
module tb_k6502_alu_seq;
  import k6502_alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [2:0]  arg_sel;
  logic [63:0] args;
  logic [7:0]  data_in, sr_in;
  logic        busy, done;
  logic [7:0]  data_out, sr_out, sr_mask;
  logic [1:0]  b_sr;

  logic        start16;
  logic [3:0]  op16;
  logic        arg_sel16;
  logic [31:0] args16;
  logic [15:0] data_in16;
  logic [7:0]  sr_in16;
  logic        busy16, done16;
  logic [15:0] data_out16;
  logic [7:0]  sr_out16, sr_mask16;
  logic [1:0]  b_sr16;

  int tests = 0;
  int fails = 0;
  int lat, nd;
  logic [7:0] last_data;

  always #5 clk = ~clk;

  k6502_alu_seq #(.WIDTH(8), .NUM_ARGS(8), .DECIMAL_EN(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .arg_sel_i(arg_sel),
    .args_i(args), .data_in_i(data_in), .sr_in_i(sr_in), .busy_o(busy),
    .done_o(done), .data_out_o(data_out), .sr_out_o(sr_out),
    .sr_mask_o(sr_mask), .b_sr_o(b_sr));

  k6502_alu_seq #(.WIDTH(16), .NUM_ARGS(2), .DECIMAL_EN(1)) u16 (
    .clk(clk), .rst_n(rst_n), .start_i(start16), .op_i(op16), .arg_sel_i(arg_sel16),
    .args_i(args16), .data_in_i(data_in16), .sr_in_i(sr_in16), .busy_o(busy16),
    .done_o(done16), .data_out_o(data_out16), .sr_out_o(sr_out16),
    .sr_mask_o(sr_mask16), .b_sr_o(b_sr16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] sr);
    op      = o;
    arg_sel = 3'd5;
    args    = {8{8'hEE}};
    args[5*8 +: 8] = a;
    data_in = b;
    sr_in   = sr;
  endtask

  // Start an op on the 8-bit DUT and return with #1 after the edge that raises done.
  task automatic go8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] sr, output int l);
    @(posedge clk); #1;
    start = 1'b1;
    drive8(o, a, b, sr);
    @(posedge clk); #1;
    start = 1'b0;
    drive8(4'hF, 8'h33, 8'h5A, 8'hFF);
    l = 1;
    while (!done && l < 30) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; drive8(4'h0, 8'h00, 8'h00, 8'h00);
    start16 = 1'b0; op16 = 4'h0; arg_sel16 = 1'b0; args16 = '0; data_in16 = '0; sr_in16 = '0;
    #12;
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_done",  {31'd0, done}, 0);
    chk("rst_outs",  {data_out, sr_out, sr_mask, 6'd0, b_sr}, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    go8(OP_ADD, 8'h50, 8'h50, 8'h00, lat);
    chk("add_lat", lat, 2);
    chk("add_data", data_out, 8'hA0);
    chk("add_sr", sr_out, 8'hC0);
    chk("add_mask", sr_mask, 8'hC3);

    go8(OP_ADD, 8'h58, 8'h46, 8'h09, lat);
    chk("dadd_lat", lat, 3);
    chk("dadd_data", data_out, 8'h05);
    chk("dadd_sr", sr_out, 8'h41);

    go8(OP_SUB, 8'h00, 8'h01, 8'h09, lat);
    chk("dsub_data", data_out, 8'h99);
    chk("dsub_sr", sr_out, 8'h80);

    go8(OP_CMP, 8'h40, 8'h40, 8'h00, lat);
    chk("cmp_data", data_out, 8'h40);
    chk("cmp_sr", sr_out, 8'h03);
    chk("cmp_mask", sr_mask, 8'h83);

    go8(OP_BAD, 8'hF0, 8'h20, 8'h00, lat);
    chk("bad_data", data_out, 8'h11);
    chk("bad_bsr", b_sr, 2'b01);
    chk("bad_mask", sr_mask, 8'h00);

    go8(OP_EOR, 8'hFF, 8'h0F, 8'h00, lat);
    chk("eor_data", data_out, 8'hF0);
    chk("eor_mask", sr_mask, 8'h82);
    go8(OP_ROR, 8'h01, 8'h00, 8'h01, lat);
    chk("ror_data", data_out, 8'h80);
    chk("ror_sr", sr_out, 8'h81);
    go8(OP_BIT, 8'h0F, 8'hC0, 8'h00, lat);
    chk("bit_data", data_out, 8'h0F);
    chk("bit_sr", sr_out, 8'hC2);
    chk("bit_mask", sr_mask, 8'hC2);
    go8(OP_DEC, 8'h00, 8'h00, 8'h00, lat);
    chk("dec_data", data_out, 8'hFF);
    chk("dec_mask", sr_mask, 8'h82);
    go8(4'hF, 8'h12, 8'h34, 8'h00, lat);
    chk("unused_lat", lat, 2);
    chk("unused_out", {data_out, sr_mask}, 16'h0000);

    // Second start one cycle into a decimal op must be dropped.
    @(posedge clk); #1;
    start = 1'b1; drive8(OP_ADD, 8'h58, 8'h46, 8'h09);
    @(posedge clk); #1;
    drive8(OP_BAD, 8'h01, 8'h01, 8'h00);
    chk("ign_busy", {31'd0, busy}, 1);
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; last_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (done) begin nd++; last_data = data_out; end
      @(posedge clk); #1;
    end
    chk("ign_ndone", nd, 1);
    chk("ign_data", last_data, 8'h05);

    // A start in the DONE cycle is accepted and completes two cycles later.
    go8(OP_ADD, 8'h10, 8'h20, 8'h00, lat);
    chk("b2b_first", data_out, 8'h30);
    start = 1'b1; drive8(OP_INC, 8'h7F, 8'h00, 8'h00);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_mid_done", {31'd0, done}, 0);
    @(posedge clk); #1;
    chk("b2b_done", {31'd0, done}, 1);
    chk("b2b_data", data_out, 8'h80);

    // Reset during DADJ clears everything at once and produces no done.
    @(posedge clk); #1;
    start = 1'b1; drive8(OP_ADD, 8'h58, 8'h46, 8'h09);
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", {30'd0, busy, done}, 0);
    chk("rst_mid_outs", {data_out, sr_out, sr_mask, 6'd0, b_sr}, 0);
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("rst_mid_nodone", nd, 0);

    @(posedge clk); #1;
    start16 = 1'b1; op16 = OP_ADD; arg_sel16 = 1'b0;
    args16 = {16'h1234, 16'h0999}; data_in16 = 16'h0001; sr_in16 = 8'h08;
    @(posedge clk); #1;
    start16 = 1'b0; args16 = '0; sr_in16 = 8'h00;
    lat = 1;
    while (!done16 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16_lat", lat, 5);
    chk("w16_data", data_out16, 16'h1000);
    chk("w16_sr", sr_out16, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
